// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
// Register file sizing and the hardwired zero register.
package cpu_pkg;

  localparam int LEN_WORD          = 32;
  localparam int LEN_REG_FILE_ADDR = 5;
  localparam int NUM_REGS          = 1 << LEN_REG_FILE_ADDR;
  localparam int ZERO_REG          = 0;

endpackage

// File: rtl/reg_file_core.sv
// Register storage: synchronous write and clear,
// two raw combinational read ports.
module reg_file_core
  import cpu_pkg::*;
#(
  parameter int LEN_WORD          = cpu_pkg::LEN_WORD,
  parameter int LEN_REG_FILE_ADDR = cpu_pkg::LEN_REG_FILE_ADDR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_we,
  input  logic [LEN_REG_FILE_ADDR-1:0] i_waddr,
  input  logic [LEN_WORD-1:0]          i_wdata,
  input  logic [LEN_REG_FILE_ADDR-1:0] i_raddr_1,
  input  logic [LEN_REG_FILE_ADDR-1:0] i_raddr_2,
  output logic [LEN_WORD-1:0]          o_rdata_1,
  output logic [LEN_WORD-1:0]          o_rdata_2
);

  localparam int DEPTH = 1 << LEN_REG_FILE_ADDR;

  logic [LEN_WORD-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_1 = r_mem[i_raddr_1];
  assign o_rdata_2 = r_mem[i_raddr_2];

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage and architectural register file with
// same-cycle bypass, retired-write counter and error flag.
module wb_reg_file
  import cpu_pkg::*;
#(
  parameter int LEN_WORD          = cpu_pkg::LEN_WORD,
  parameter int LEN_REG_FILE_ADDR = cpu_pkg::LEN_REG_FILE_ADDR,
  parameter int LEN_COUNT         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEN_WORD-1:0]          read_data_mem,
  input  logic [LEN_WORD-1:0]          alu_out,
  input  logic [LEN_REG_FILE_ADDR-1:0] write_reg,
  input  logic                         mem_read,
  input  logic                         reg_write,
  input  logic                         mem_to_reg,
  input  logic [LEN_REG_FILE_ADDR-1:0] read_reg_1,
  input  logic [LEN_REG_FILE_ADDR-1:0] read_reg_2,
  output logic [LEN_WORD-1:0]          read_data_1,
  output logic [LEN_WORD-1:0]          read_data_2,
  output logic [LEN_WORD-1:0]          wb_data,
  output logic                         wb_en,
  output logic [LEN_COUNT-1:0]         write_count,
  output logic                         protocol_err
);

  localparam logic [LEN_REG_FILE_ADDR-1:0] W_ZERO =
    LEN_REG_FILE_ADDR'(ZERO_REG);

  logic [LEN_WORD-1:0]  w_raw_1;
  logic [LEN_WORD-1:0]  w_raw_2;
  logic                 w_err_cond;
  logic                 w_cnt_full;
  logic [LEN_COUNT-1:0] r_count;
  logic                 r_err;

  assign wb_data = mem_to_reg ? read_data_mem : alu_out;
  assign wb_en   = reg_write && (write_reg != W_ZERO);

  // Load data chosen for an instruction that did not load.
  assign w_err_cond = reg_write && mem_to_reg && !mem_read;
  assign w_cnt_full = &r_count;

  reg_file_core #(
    .LEN_WORD          (LEN_WORD),
    .LEN_REG_FILE_ADDR (LEN_REG_FILE_ADDR)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_we      (wb_en),
    .i_waddr   (write_reg),
    .i_wdata   (wb_data),
    .i_raddr_1 (read_reg_1),
    .i_raddr_2 (read_reg_2),
    .o_rdata_1 (w_raw_1),
    .o_rdata_2 (w_raw_2)
  );

  always_comb begin
    read_data_1 = w_raw_1;
    priority case (1'b1)
      (read_reg_1 == W_ZERO):
        read_data_1 = '0;
      (wb_en && read_reg_1 == write_reg):
        read_data_1 = wb_data;
      default:
        read_data_1 = w_raw_1;
    endcase
  end

  always_comb begin
    read_data_2 = w_raw_2;
    priority case (1'b1)
      (read_reg_2 == W_ZERO):
        read_data_2 = '0;
      (wb_en && read_reg_2 == write_reg):
        read_data_2 = wb_data;
      default:
        read_data_2 = w_raw_2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (wb_en && !w_cnt_full) begin
        r_count <= r_count + LEN_COUNT'(1);
      end
      if (w_err_cond) begin
        r_err <= 1'b1;
      end
    end
  end

  assign write_count  = r_count;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed and random checks of wb_reg_file against
// an array-based model of the architectural registers.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_data_mem;
  logic [31:0] alu_out;
  logic [4:0]  write_reg;
  logic        mem_read;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [31:0] write_count;
  logic        protocol_err;

  logic [31:0] s_rd1;
  logic [31:0] s_rd2;
  logic [31:0] s_wbd;
  logic        s_wbe;
  logic [3:0]  s_cnt;
  logic        s_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]       m_regs [32];
  longint unsigned   m_count;
  int                m_c4;
  bit                m_err;

  always #5 clk = ~clk;

  wb_reg_file u_dut (
    .clk           (clk),
    .reset         (reset),
    .read_data_mem (read_data_mem),
    .alu_out       (alu_out),
    .write_reg     (write_reg),
    .mem_read      (mem_read),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .read_reg_1    (read_reg_1),
    .read_reg_2    (read_reg_2),
    .read_data_1   (read_data_1),
    .read_data_2   (read_data_2),
    .wb_data       (wb_data),
    .wb_en         (wb_en),
    .write_count   (write_count),
    .protocol_err  (protocol_err)
  );

  wb_reg_file #(.LEN_COUNT(4)) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .read_data_mem (read_data_mem),
    .alu_out       (alu_out),
    .write_reg     (write_reg),
    .mem_read      (mem_read),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .read_reg_1    (read_reg_1),
    .read_reg_2    (read_reg_2),
    .read_data_1   (s_rd1),
    .read_data_2   (s_rd2),
    .wb_data       (s_wbd),
    .wb_en         (s_wbe),
    .write_count   (s_cnt),
    .protocol_err  (s_err)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wbd();
    return mem_to_reg ? read_data_mem : alu_out;
  endfunction

  function automatic bit m_wbe();
    return reg_write && write_reg != 0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_wbe() && a == write_reg) return m_wbd();
    return m_regs[a];
  endfunction

  task automatic drive(bit rst, logic [31:0] ld,
                       logic [31:0] alu, logic [4:0] wr,
                       bit mr, bit rw, bit m2r,
                       logic [4:0] r1, logic [4:0] r2);
    reset = rst;
    read_data_mem = ld;
    alu_out = alu;
    write_reg = wr;
    mem_read = mr;
    reg_write = rw;
    mem_to_reg = m2r;
    read_reg_1 = r1;
    read_reg_2 = r2;
  endtask

  task automatic check_comb();
    #1;
    chk("rd1", read_data_1, m_read(read_reg_1));
    chk("rd2", read_data_2, m_read(read_reg_2));
    chk("wb_data", wb_data, m_wbd());
    chk("wb_en", 32'(wb_en), 32'(m_wbe()));
    chk("rd1_c4", s_rd1, m_read(read_reg_1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_count = 0;
      m_c4 = 0;
      m_err = 0;
    end else begin
      if (m_wbe()) begin
        m_regs[write_reg] = m_wbd();
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_c4 < 15) m_c4++;
      end
      if (reg_write && mem_to_reg && !mem_read) m_err = 1;
    end
    #1;
    chk("count", write_count, m_count[31:0]);
    chk("count4", 32'(s_cnt), 32'(m_c4));
    chk("err", 32'(protocol_err), 32'(m_err));
  endtask

  task automatic cycle();
    check_comb();
    tick();
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_count = 0;
    m_c4 = 0;
    m_err = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_comb();
    tick();
    cycle();

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      #1;
      chk("rst_rd1", read_data_1, 32'h0);
      chk("rst_rd2", read_data_2, 32'h0);
    end
    chk("rst_cnt", write_count, 32'h0);
    chk("rst_err", 32'(protocol_err), 32'h0);

    drive(0, 0, 32'h1234_5678, 5, 0, 1, 0, 5, 3);
    #1;
    chk("byp5", read_data_1, 32'h1234_5678);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1;
    chk("held5", read_data_1, 32'h1234_5678);
    chk("cnt1", write_count, 32'd1);
    cycle();

    drive(0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);
    #1;
    chk("r0_rd1", read_data_1, 32'h0);
    chk("r0_wbe", 32'(wb_en), 32'h0);
    cycle();
    chk("r0_cnt", write_count, 32'd1);

    drive(0, 32'hDEAD_BEEF, 0, 31, 1, 1, 1, 31, 31);
    #1;
    chk("ld_rd1", read_data_1, 32'hDEAD_BEEF);
    chk("ld_rd2", read_data_2, 32'hDEAD_BEEF);
    chk("ld_wbd", wb_data, 32'hDEAD_BEEF);
    cycle();

    drive(0, 32'h5555_0000, 32'h1, 9, 0, 1, 1, 9, 0);
    cycle();
    chk("err_set", 32'(protocol_err), 32'h1);
    chk("err_wr", m_regs[9], 32'h5555_0000);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 9, 31);
      cycle();
    end
    chk("err_hold", 32'(protocol_err), 32'h1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("err_clr", 32'(protocol_err), 32'h0);

    drive(0, 0, 32'hA5A5_A5A5, 7, 0, 1, 0, 7, 8);
    cycle();
    drive(1, 0, 32'h0BAD_0BAD, 8, 0, 1, 0, 7, 8);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 8);
    #1;
    chk("mid_r7", read_data_1, 32'h0);
    chk("mid_r8", read_data_2, 32'h0);
    chk("mid_cnt", write_count, 32'h0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      bit mr;
      bit m2r;
      wr = 5'($urandom_range(0, 31));
      mr = 1'($urandom);
      m2r = mr ? 1'($urandom) : ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 59) == 0),
            $urandom, $urandom, wr, mr,
            ($urandom_range(0, 3) != 0), m2r,
            ($urandom_range(0, 2) == 0) ? wr
              : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr
              : 5'($urandom_range(0, 31)));
      cycle();
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 32'(i * 3 + 1), 5'(1 + i), 0, 1, 0,
            5'(1 + i), 5'(i));
      cycle();
    end
    chk("sat4", 32'(s_cnt), 32'd15);
    chk("cnt20", write_count, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Write-back stage plus architectural register file. It is the consumer end of the memory-to-write-back pipeline register.
- Takes the registered M/WB fields, selects the write-back value and commits it to a 2^LEN_REG_FILE_ADDR x LEN_WORD register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Also exports the write-back value for EX forwarding, a retired-write counter and a sticky protocol-error flag.

Parameters:
- LEN_WORD, 32, data word width.
- LEN_REG_FILE_ADDR, 5, register address width; the file holds 2^LEN_REG_FILE_ADDR entries.
- LEN_COUNT, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- read_data_mem  in  LEN_WORD  load data from M/WB register.
- alu_out  in  LEN_WORD  ALU result from M/WB register.
- write_reg  in  LEN_REG_FILE_ADDR  destination register from M/WB.
- mem_read  in  1  instruction in WB is a load.
- reg_write  in  1  instruction in WB writes a register.
- mem_to_reg  in  1  select load data (1) or ALU result (0).
- read_reg_1  in  LEN_REG_FILE_ADDR  decode read address A.
- read_reg_2  in  LEN_REG_FILE_ADDR  decode read address B.
- read_data_1  out  LEN_WORD  operand A.
- read_data_2  out  LEN_WORD  operand B.
- wb_data  out  LEN_WORD  selected write-back value, for the forwarding unit.
- wb_en  out  1  effective write enable, for the forwarding unit.
- write_count  out  LEN_COUNT  number of committed register writes.
- protocol_err  out  1  sticky control-inconsistency flag.

Behaviour:
- Reset is synchronous and active-high, using the codebase's port names clk and reset.
  - On a reset posedge: every register entry, write_count and protocol_err become 0.
  - No register write occurs in a reset cycle, even if wb_en=1.
- wb_data is combinational: mem_to_reg ? read_data_mem : alu_out.
- wb_en is combinational: reg_write && (write_reg != 0).
- Register 0 is hardwired to zero.
  - Writes to it are discarded.
  - Reads of it return 0 regardless of bypass.
- Write: on posedge with reset=0 and wb_en=1, regs[write_reg] <= wb_data. Latency is one edge.
- Read ports are combinational, evaluated in priority order per port:
  1. addr == 0 gives 0.
  2. wb_en && addr == write_reg gives wb_data (bypass). The value written this cycle is visible to decode in the same cycle, so there is no half-cycle write requirement.
  3. Otherwise regs[addr].
- Both ports may address the same register. Each port resolves independently, so both may bypass.
- write_count:
  - Increments by 1 on each posedge with reset=0 and wb_en=1.
  - Saturates at all-ones; no wrap.
  - A write to register 0 does not count.
- protocol_err:
  - Set on posedge when reset=0 and reg_write && mem_to_reg && !mem_read (load data selected for a non-load).
  - Stays 1 until reset.
  - The write itself still commits.
- Inputs are already registered by M/WB. This block adds no pipeline stage on the write path.
- Reset asserted mid-stream: the state is cleared on that edge, and reads after it return 0 until new writes commit.

Decomposition:
- Shared package cpu_pkg:
  - LEN_WORD and LEN_REG_FILE_ADDR defaults.
  - ZERO_REG = 0.
  - NUM_REGS = 2^LEN_REG_FILE_ADDR.
- Sub-module reg_file_core holds the storage array:
  - Synchronous write port and synchronous reset clear.
  - Two raw combinational read ports.
- The top level holds the write-back mux, zero/bypass read logic, counter and error flag.

Test Plan:
- Reset, then read all addresses on both ports -> every read = 0, write_count = 0, protocol_err = 0.
- reg_write=1, write_reg=5, mem_to_reg=0, alu_out=0x1234_5678, read_reg_1=5 in the same cycle -> read_data_1 = 0x1234_5678 before the edge; after the edge, with reg_write=0, still 0x1234_5678; write_count = 1.
- reg_write=1, write_reg=0, alu_out=0xFFFF_FFFF, read_reg_1=read_reg_2=0 -> reads = 0, wb_en = 0, write_count unchanged.
- mem_read=1, mem_to_reg=1, read_data_mem=0xDEAD_BEEF, write_reg=31, read_reg_1=read_reg_2=31 -> both ports = 0xDEAD_BEEF; wb_data = 0xDEAD_BEEF.
- mem_to_reg=1, mem_read=0, reg_write=1 for one cycle -> protocol_err = 1 after the edge and held for 10 idle cycles; reset -> 0.
- Write reg 7 = 0xA5A5_A5A5, then assert reset in the same cycle as a write to reg 8 -> after the edge reg 7 = 0, reg 8 = 0, write_count = 0.
- LEN_COUNT=4 build: 20 valid writes -> write_count = 15 (saturated).
